// File: rtl/gf2027_pkg.sv
// Shared types and constants for the GF(2027) multiply front end.
// Widths are sized so the folded product always fits the 21-bit Barrett reducer input.
package gf2027_pkg;

    localparam int unsigned Q      = 2027;
    localparam int unsigned W      = 11;
    localparam int unsigned PW     = 21;
    localparam int unsigned FOLD_C = 2075648;

    typedef logic [W-1:0]   residue_t;
    typedef logic [2*W-1:0] raw_t;
    typedef logic [PW-1:0]  fold_t;
    typedef logic [3:0]     iter_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        FOLD,
        DONE
    } state_t;

    localparam residue_t Q_RES      = residue_t'(Q);
    localparam raw_t     FOLD_C_RAW = raw_t'(FOLD_C);
    localparam iter_t    LAST_ITER  = iter_t'(W - 1);

    // Inputs never exceed 2047 < 2Q, so one conditional subtract yields a residue.
    function automatic residue_t pre_reduce(input residue_t x);
        return (x >= Q_RES) ? residue_t'(x - Q_RES) : x;
    endfunction

endpackage

// File: rtl/gf2027_fold21.sv
// Combinational 22->21-bit fold: subtracts Q*2^10 once when the raw product reaches 2^21.
// Result stays congruent mod Q and is guaranteed below 2^21 for any product of two residues.
module gf2027_fold21
    import gf2027_pkg::*;
(
    input  logic [2*W-1:0] raw,
    output logic [PW-1:0]  folded
);

    raw_t diff;

    always_comb begin
        diff   = raw - FOLD_C_RAW;
        folded = raw[2*W-1] ? diff[PW-1:0] : raw[PW-1:0];
    end

endmodule

// File: rtl/gf2027_mul_front.sv
// Iterative radix-2 shift-add multiplier for GF(2027) operands with a folded 21-bit result
// presented over a valid/ready handshake to the downstream Barrett reducer.
module gf2027_mul_front
    import gf2027_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_prod,
    output logic          busy
);

    state_t   state_q, state_d;
    residue_t a_q, a_d;
    residue_t b_q, b_d;
    raw_t     acc_q, acc_d;
    iter_t    count_q, count_d;
    fold_t    out_prod_q, out_prod_d;
    logic     out_valid_q, out_valid_d;

    fold_t    fold_out;
    raw_t     partial;

    gf2027_fold21 u_fold (
        .raw    (acc_q),
        .folded (fold_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            out_prod_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_prod_q  <= out_prod_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)              state_d = MUL;
            MUL:     if (count_q == LAST_ITER)  state_d = FOLD;
            FOLD:                               state_d = DONE;
            DONE:    if (out_ready)             state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_prod_d  = out_prod_q;
        out_valid_d = out_valid_q;
        partial     = b_q[count_q] ? (raw_t'(a_q) << count_q) : '0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = pre_reduce(in_a);
                    b_d     = pre_reduce(in_b);
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            MUL: begin
                acc_d   = acc_q + partial;
                count_d = count_q + iter_t'(1);
            end
            FOLD: begin
                out_prod_d  = fold_out;
                out_valid_d = 1'b1;
            end
            DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = out_valid_q;
        out_prod  = out_prod_q;
    end

endmodule

// File: tb/tb_gf2027_mul_front.sv
// Directed bench for gf2027_mul_front: latency, fold boundary, backpressure, reset abort, back-to-back.
module tb_gf2027_mul_front;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] in_a = '0;
    logic [10:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [20:0] out_prod;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    gf2027_mul_front dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair and returns #1 after the accept edge.
    task automatic send(input logic [10:0] a, input logic [10:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    // Counts clock edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        checks++;
        if (out_prod !== 21'd0) begin errors++; $display("FAIL reset_out_prod: got %0d required 0", out_prod); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        send(11'd3, 11'd5);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b required 1", busy); end
        wait_valid(lat);
        // Valid appears after edge t+12, i.e. in the 13th cycle following the accept edge.
        checks++;
        if (lat !== 12) begin errors++; $display("FAIL basic_latency: got %0d edges required 12", lat); end
        checks++;
        if (out_prod !== 21'd15) begin errors++; $display("FAIL basic_prod: got %0d required 15", out_prod); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: out_valid=%0b required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %0b required 1", in_ready); end
    endtask

    task automatic test_products();
        logic [10:0] ta [5];
        logic [10:0] tb [5];
        logic [20:0] exp_p [5];
        int lat;
        ta[0] = 11'd2026; tb[0] = 11'd2026; exp_p[0] = 21'd2029028;
        ta[1] = 11'd2047; tb[1] = 11'd100;  exp_p[1] = 21'd2000;
        ta[2] = 11'd0;    tb[2] = 11'd1234; exp_p[2] = 21'd0;
        ta[3] = 11'd2027; tb[3] = 11'd5;    exp_p[3] = 21'd0;
        ta[4] = 11'd2047; tb[4] = 11'd2047; exp_p[4] = 21'd400;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(ta[i], tb[i]);
            wait_valid(lat);
            checks++;
            if (!out_valid || out_prod !== exp_p[i]) begin
                errors++;
                $display("FAIL product_%0d: a=%0d b=%0d got %0d (valid=%0b) required %0d",
                         i, ta[i], tb[i], out_prod, out_valid, exp_p[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send(11'd45, 11'd45);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_prod !== 21'd2025 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold_%0d: valid=%0b prod=%0d in_ready=%0b required 1/2025/0",
                         i, out_valid, out_prod, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        out_ready = 1'b1;
        send(11'd11, 11'd13);
        repeat (5) step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_prod !== 21'd0) begin
            errors++;
            $display("FAIL reset_mid_async: busy=%0b in_ready=%0b valid=%0b prod=%0d required 0/1/0/0",
                     busy, in_ready, out_valid, out_prod);
        end
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
        send(11'd7, 11'd9);
        wait_valid(lat);
        checks++;
        if (lat !== 12 || out_prod !== 21'd63) begin
            errors++;
            $display("FAIL reset_mid_recover: latency=%0d prod=%0d required 12/63", lat, out_prod);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n, t1, t2, lat;
        logic [20:0] first_p;
        logic        seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 11'd2;
        in_b      = 11'd2;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        step();
        t1 = cyc;
        in_a = 11'd1000;
        in_b = 11'd1000;
        seen = 1'b0;
        first_p = '0;
        n = 0;
        while (!in_ready && n < 50) begin
            if (out_valid && !seen) begin seen = 1'b1; first_p = out_prod; end
            step();
            n++;
        end
        step();
        t2 = cyc;
        in_valid = 1'b0;
        checks++;
        if (!seen || first_p !== 21'd4) begin
            errors++;
            $display("FAIL b2b_first: seen=%0b prod=%0d required 1/4", seen, first_p);
        end
        checks++;
        if (t2 - t1 !== 14) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles required 14", t2 - t1);
        end
        wait_valid(lat);
        checks++;
        if (!out_valid || out_prod !== 21'd1000000) begin
            errors++;
            $display("FAIL b2b_second: valid=%0b prod=%0d required 1/1000000", out_valid, out_prod);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_products();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
